dmac_ahbl_regs: RTL and testbench
=================================

Name: dmac_ahbl_regs

Overview:
- AHB-Lite slave register file that programs and monitors the DMA engine (the AHB-Lite master in this codebase).
- Sits on the system bus behind the decoder's HSEL.
- Drives the engine's configuration, start and trigger inputs, and collects busy/done.
- Latches a sticky completion flag and raises a level interrupt.

Parameters:
- ADDR_BITS, 6, number of HADDR LSBs decoded (word offset = HADDR[ADDR_BITS-1:2]).

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  write.
- HREADY  in  1  bus ready (qualifies the address phase).
- HWDATA  in  32  write data.
- HREADYOUT  out  1  slave ready; constant 1.
- HRDATA  out  32  read data.
- HRESP  out  1  constant 0 (OKAY).
- saddr, daddr  out  32 each  source/destination base.
- ssize, dsize, sinc, dinc  out  3 each  sizes and address increments.
- bsize  out  16  block size.
- bcount  out  8  block count.
- wfi  out  1  wait-for-IRQ enable.
- irqsrc  out  3  peripheral IRQ index.
- icra, icrv  out  32 each  IRQ-clear register address/value.
- start  out  1  one-cycle start pulse to engine.
- busy  in  1  engine busy.
- done  in  1  engine one-cycle done pulse.
- irq  out  1  interrupt = done_flag & ie.

Behaviour:
- Clock/reset: single clock HCLK; reset HRESETn asynchronous, active-low.
- Reset values: all registers, outputs, start, irq, done_flag and data-phase state are 0. HREADYOUT=1 and HRESP=0 at all times. Assertion of HRESETn mid-transfer aborts the pending data phase and writes nothing.
- Address phase: accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register the word offset, HWRITE and HSIZE; a valid-flag marks the next cycle as the data phase.
- Zero wait states.
- Reads: HRDATA is combinational from the registered offset during the data phase, 0 otherwise.
- Writes: commit HWDATA at the end of the data phase. Only HSIZE==3'b010 writes take effect; sub-word writes are ignored with OKAY. Back-to-back transfers with no idle cycle must work.
- Register map (byte offset):
  - 0x00 SADDR rw.
  - 0x04 DADDR rw.
  - 0x08 XFER rw: [2:0] ssize, [6:4] dsize, [10:8] sinc, [14:12] dinc.
  - 0x0C BSIZE rw [15:0].
  - 0x10 BCOUNT rw [7:0].
  - 0x14 TRIG rw: [0] wfi, [6:4] irqsrc.
  - 0x18 ICRA rw.
  - 0x1C ICRV rw.
  - 0x20 CTRL: [0] START wo (reads 0), [1] ie rw.
  - 0x24 STATUS: [0] busy ro, [1] done_flag w1c.
  - Unmapped fields read 0. Unmapped offsets read 0 and ignore writes.
- lock = busy | start.
  - While lock=1, writes to 0x00–0x1C are ignored, so the engine sees stable configuration.
  - CTRL.ie and STATUS w1c are always writable.
- Start:
  - A committed CTRL write with bit0=1 while lock=0 sets start=1 for exactly the next cycle.
  - The same write clears done_flag.
  - START writes while lock=1 are dropped, with no queueing.
  - ie in that write is applied regardless of lock.
- done_flag:
  - Set by the done pulse.
  - Cleared by a STATUS write with bit1=1, or by an accepted START.
  - If set and clear land in the same cycle, set wins.
- irq: registered-free AND of done_flag and ie. Asserts the cycle after the done pulse and stays high until cleared or ie=0.
- busy is passed through to STATUS[0] without delay.

Test Plan:
- Reset mid-sequence: program all registers, then pulse HRESETn low during a write data phase -> all outputs 0, and a readback of every register returns 0.
- Program and readback: write SADDR=0x2000_0000, DADDR=0x4000_0010, XFER=0x0000_4210, BSIZE=0x0010, BCOUNT=0x03, TRIG=0x31, then read back back-to-back -> identical values; outputs ssize=0, dsize=1, sinc=2, dinc=4, wfi=1, irqsrc=3.
- Start handshake: write CTRL=0x3 -> start high for exactly 1 cycle after the data phase. Then hold busy=1 and write SADDR=0x1234 -> SADDR unchanged. Write CTRL=0x1 again -> no start pulse.
- Completion and interrupt: with ie=1, pulse done -> STATUS reads 0x2 and irq=1 from the next cycle. Write STATUS=0x2 -> irq=0. Pulse done on the same cycle as the w1c data phase -> done_flag stays 1.
- Size and decode rules: byte write (HSIZE=0) of 0xFF to BSIZE -> unchanged. Read of offset 0x28 -> 0. HTRANS=IDLE with HSEL=1 -> no write. HREADY=0 at the address phase -> transfer not accepted.

Source files
------------

// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite register file for the DMA engine: configuration, start pulse, busy/done status, level IRQ.
// Zero wait states (HREADYOUT=1, OKAY always); writes commit at data-phase end, reads are combinational.
module dmac_ahbl_regs #(
    parameter int ADDR_BITS = 6
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [31:0] saddr,
    output logic [31:0] daddr,
    output logic [2:0]  ssize,
    output logic [2:0]  dsize,
    output logic [2:0]  sinc,
    output logic [2:0]  dinc,
    output logic [15:0] bsize,
    output logic [7:0]  bcount,
    output logic        wfi,
    output logic [2:0]  irqsrc,
    output logic [31:0] icra,
    output logic [31:0] icrv,
    output logic        start,
    input  logic        busy,
    input  logic        done,
    output logic        irq
);
    localparam int OFF_W = ADDR_BITS - 2;

    localparam logic [OFF_W-1:0] OFF_SADDR  = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_DADDR  = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_XFER   = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_BSIZE  = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_BCOUNT = OFF_W'(4);
    localparam logic [OFF_W-1:0] OFF_TRIG   = OFF_W'(5);
    localparam logic [OFF_W-1:0] OFF_ICRA   = OFF_W'(6);
    localparam logic [OFF_W-1:0] OFF_ICRV   = OFF_W'(7);
    localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(8);
    localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(9);

    // Data-phase state captured from the accepted address phase
    logic             dph_vld_q,  dph_vld_d;
    logic             dph_wr_q,   dph_wr_d;
    logic [OFF_W-1:0] dph_off_q,  dph_off_d;
    logic [2:0]       dph_size_q, dph_size_d;

    logic [31:0] saddr_q,  saddr_d;
    logic [31:0] daddr_q,  daddr_d;
    logic [2:0]  ssize_q,  ssize_d;
    logic [2:0]  dsize_q,  dsize_d;
    logic [2:0]  sinc_q,   sinc_d;
    logic [2:0]  dinc_q,   dinc_d;
    logic [15:0] bsize_q,  bsize_d;
    logic [7:0]  bcount_q, bcount_d;
    logic        wfi_q,    wfi_d;
    logic [2:0]  irqsrc_q, irqsrc_d;
    logic [31:0] icra_q,   icra_d;
    logic [31:0] icrv_q,   icrv_d;
    logic        ie_q,     ie_d;
    logic        start_q,  start_d;
    logic        done_flag_q, done_flag_d;

    logic        addr_acc;
    logic        wr_en;
    logic        lock;
    logic        cfg_wr;
    logic        done_clr;
    logic [31:0] rd_dat;

    logic unused_ok;
    assign unused_ok = ^{HADDR[31:ADDR_BITS], HADDR[1:0], HTRANS[0]};

    always_comb begin
        addr_acc   = HSEL & HTRANS[1] & HREADY;
        dph_vld_d  = addr_acc;
        dph_wr_d   = addr_acc ? HWRITE : dph_wr_q;
        dph_off_d  = addr_acc ? HADDR[ADDR_BITS-1:2] : dph_off_q;
        dph_size_d = addr_acc ? HSIZE : dph_size_q;
    end

    // Configuration is frozen while the engine runs or is being kicked off
    always_comb begin
        wr_en    = dph_vld_q & dph_wr_q & (dph_size_q == 3'b010);
        lock     = busy | start_q;
        cfg_wr   = wr_en & ~lock;
        saddr_d  = saddr_q;
        daddr_d  = daddr_q;
        ssize_d  = ssize_q;
        dsize_d  = dsize_q;
        sinc_d   = sinc_q;
        dinc_d   = dinc_q;
        bsize_d  = bsize_q;
        bcount_d = bcount_q;
        wfi_d    = wfi_q;
        irqsrc_d = irqsrc_q;
        icra_d   = icra_q;
        icrv_d   = icrv_q;
        ie_d     = ie_q;
        start_d  = 1'b0;
        done_clr = 1'b0;

        if (cfg_wr) begin
            case (dph_off_q)
                OFF_SADDR:  saddr_d  = HWDATA;
                OFF_DADDR:  daddr_d  = HWDATA;
                OFF_XFER: begin
                    ssize_d = HWDATA[2:0];
                    dsize_d = HWDATA[6:4];
                    sinc_d  = HWDATA[10:8];
                    dinc_d  = HWDATA[14:12];
                end
                OFF_BSIZE:  bsize_d  = HWDATA[15:0];
                OFF_BCOUNT: bcount_d = HWDATA[7:0];
                OFF_TRIG: begin
                    wfi_d    = HWDATA[0];
                    irqsrc_d = HWDATA[6:4];
                end
                OFF_ICRA:   icra_d   = HWDATA;
                OFF_ICRV:   icrv_d   = HWDATA;
                default: ;
            endcase
        end

        if (wr_en) begin
            case (dph_off_q)
                OFF_CTRL: begin
                    ie_d = HWDATA[1];
                    if (HWDATA[0] && !lock) begin
                        start_d  = 1'b1;
                        done_clr = 1'b1;
                    end
                end
                OFF_STATUS: done_clr = HWDATA[1];
                default: ;
            endcase
        end

        // A done pulse in the same cycle as a clear keeps the flag set
        done_flag_d = done | (done_flag_q & ~done_clr);
    end

    always_comb begin
        rd_dat = 32'd0;
        case (dph_off_q)
            OFF_SADDR:  rd_dat = saddr_q;
            OFF_DADDR:  rd_dat = daddr_q;
            OFF_XFER:   rd_dat = {17'd0, dinc_q, 1'b0, sinc_q, 1'b0, dsize_q, 1'b0, ssize_q};
            OFF_BSIZE:  rd_dat = {16'd0, bsize_q};
            OFF_BCOUNT: rd_dat = {24'd0, bcount_q};
            OFF_TRIG:   rd_dat = {25'd0, irqsrc_q, 3'd0, wfi_q};
            OFF_ICRA:   rd_dat = icra_q;
            OFF_ICRV:   rd_dat = icrv_q;
            OFF_CTRL:   rd_dat = {30'd0, ie_q, 1'b0};
            OFF_STATUS: rd_dat = {30'd0, done_flag_q, busy};
            default:    rd_dat = 32'd0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_vld_q   <= 1'b0;
            dph_wr_q    <= 1'b0;
            dph_off_q   <= '0;
            dph_size_q  <= 3'd0;
            saddr_q     <= 32'd0;
            daddr_q     <= 32'd0;
            ssize_q     <= 3'd0;
            dsize_q     <= 3'd0;
            sinc_q      <= 3'd0;
            dinc_q      <= 3'd0;
            bsize_q     <= 16'd0;
            bcount_q    <= 8'd0;
            wfi_q       <= 1'b0;
            irqsrc_q    <= 3'd0;
            icra_q      <= 32'd0;
            icrv_q      <= 32'd0;
            ie_q        <= 1'b0;
            start_q     <= 1'b0;
            done_flag_q <= 1'b0;
        end else begin
            dph_vld_q   <= dph_vld_d;
            dph_wr_q    <= dph_wr_d;
            dph_off_q   <= dph_off_d;
            dph_size_q  <= dph_size_d;
            saddr_q     <= saddr_d;
            daddr_q     <= daddr_d;
            ssize_q     <= ssize_d;
            dsize_q     <= dsize_d;
            sinc_q      <= sinc_d;
            dinc_q      <= dinc_d;
            bsize_q     <= bsize_d;
            bcount_q    <= bcount_d;
            wfi_q       <= wfi_d;
            irqsrc_q    <= irqsrc_d;
            icra_q      <= icra_d;
            icrv_q      <= icrv_d;
            ie_q        <= ie_d;
            start_q     <= start_d;
            done_flag_q <= done_flag_d;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign HRDATA    = dph_vld_q ? rd_dat : 32'd0;
    assign saddr     = saddr_q;
    assign daddr     = daddr_q;
    assign ssize     = ssize_q;
    assign dsize     = dsize_q;
    assign sinc      = sinc_q;
    assign dinc      = dinc_q;
    assign bsize     = bsize_q;
    assign bcount    = bcount_q;
    assign wfi       = wfi_q;
    assign irqsrc    = irqsrc_q;
    assign icra      = icra_q;
    assign icrv      = icrv_q;
    assign start     = start_q;
    assign irq       = done_flag_q & ie_q;

endmodule

// File: tb/tb_dmac_ahbl_regs.sv
// Directed bench for dmac_ahbl_regs: register-array model checked every cycle plus literal expectations.
module tb_dmac_ahbl_regs;
    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = 32'd0;
    logic [1:0]  HTRANS  = 2'b00;
    logic [2:0]  HSIZE   = 3'd0;
    logic        HWRITE  = 1'b0;
    logic        HREADY  = 1'b1;
    logic [31:0] HWDATA  = 32'd0;
    logic        busy    = 1'b0;
    logic        done    = 1'b0;
    logic        HREADYOUT, HRESP, start, irq, wfi;
    logic [31:0] HRDATA, saddr, daddr, icra, icrv;
    logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
    logic [15:0] bsize;
    logic [7:0]  bcount;

    always #5 HCLK = ~HCLK;

    dmac_ahbl_regs #(.ADDR_BITS(6)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .saddr(saddr), .daddr(daddr), .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc),
        .bsize(bsize), .bcount(bcount), .wfi(wfi), .irqsrc(irqsrc), .icra(icra), .icrv(icrv),
        .start(start), .busy(busy), .done(done), .irq(irq)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_reg [0:7];
    logic        m_ie = 1'b0, m_flag = 1'b0, m_start = 1'b0, m_dph = 1'b0, m_wr = 1'b0;
    logic [3:0]  m_off = 4'd0;
    logic [2:0]  m_size = 3'd0;

    function automatic logic [31:0] mask(input int i);
        case (i)
            2:       return 32'h0000_7777;
            3:       return 32'h0000_FFFF;
            4:       return 32'h0000_00FF;
            5:       return 32'h0000_0071;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [3:0] o);
        if (o < 4'd8) return m_reg[o[2:0]];
        if (o == 4'd8) return {30'd0, m_ie, 1'b0};
        if (o == 4'd9) return {30'd0, m_flag, busy};
        return 32'd0;
    endfunction

    wire m_wen  = m_dph && m_wr && (m_size == 3'd2);
    wire m_lock = busy || m_start;
    wire m_go   = m_wen && (m_off == 4'd8) && HWDATA[0] && !m_lock;
    wire m_clr  = m_go || (m_wen && (m_off == 4'd9) && HWDATA[1]);

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 8; i++) m_reg[i] <= 32'd0;
            m_ie <= 1'b0; m_flag <= 1'b0; m_start <= 1'b0; m_dph <= 1'b0;
            m_wr <= 1'b0; m_off <= 4'd0; m_size <= 3'd0;
        end else begin
            if (m_wen && m_off < 4'd8 && !m_lock) m_reg[m_off[2:0]] <= HWDATA & mask(int'(m_off));
            if (m_wen && m_off == 4'd8) m_ie <= HWDATA[1];
            m_flag  <= done ? 1'b1 : (m_clr ? 1'b0 : m_flag);
            m_start <= m_go;
            m_dph   <= HSEL && HTRANS[1] && HREADY;
            m_off   <= HADDR[5:2];
            m_wr    <= HWRITE;
            m_size  <= HSIZE;
        end
    end

    always @(negedge HCLK) begin
        chk("saddr", saddr, m_reg[0]);
        chk("daddr", daddr, m_reg[1]);
        chk("xfer", {17'd0, dinc, 1'b0, sinc, 1'b0, dsize, 1'b0, ssize}, m_reg[2]);
        chk("bsize", {16'd0, bsize}, m_reg[3]);
        chk("bcount", {24'd0, bcount}, m_reg[4]);
        chk("trig", {25'd0, irqsrc, 3'd0, wfi}, m_reg[5]);
        chk("icra", icra, m_reg[6]);
        chk("icrv", icrv, m_reg[7]);
        chk("start", 32'(start), 32'(m_start));
        chk("irq", 32'(irq), 32'(m_flag & m_ie));
        chk("hreadyout", 32'(HREADYOUT), 32'd1);
        chk("hresp", 32'(HRESP), 32'd0);
        if (!m_dph) chk("hrdata_idle", HRDATA, 32'd0);
        else if (!m_wr) chk("hrdata", HRDATA, m_rd(m_off));
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        @(posedge HCLK);
        #1;
        HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HSIZE = sz; HWDATA = wd;
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 3'd0, wd);
    endtask

    // Returns one cycle after the commit edge
    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, 2'b10, 1'b1, a, 3'd2, 32'd0);
        idle(d);
        idle(32'd0);
    endtask

    task automatic rd32(input logic [31:0] a, input logic [31:0] exp, input string nm);
        cyc(1'b1, 2'b10, 1'b0, a, 3'd2, 32'd0);
        idle(32'd0);
        #1 chk(nm, HRDATA, exp);
    endtask

    logic [31:0] pdat [0:7];

    initial begin
        pdat = '{32'h2000_0000, 32'h4000_0010, 32'h0000_4210, 32'h0000_0010,
                 32'h0000_0003, 32'h0000_0031, 32'h4000_1000, 32'h0000_0001};
        #2 HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        #1;
        chk("rst_saddr", saddr, 32'd0);
        chk("rst_bcount", 32'(bcount), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);

        // Back-to-back programming then back-to-back readback
        cyc(1'b1, 2'b10, 1'b1, 32'd0, 3'd2, 32'd0);
        for (int i = 1; i < 8; i++) cyc(1'b1, 2'b10, 1'b1, 32'(i * 4), 3'd2, pdat[i-1]);
        idle(pdat[7]);
        cyc(1'b1, 2'b10, 1'b0, 32'd0, 3'd2, 32'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 2'b10, 1'b0, 32'(i * 4), 3'd2, 32'd0);
            #1 chk($sformatf("readback_%0d", i - 1), HRDATA, pdat[i-1]);
        end
        idle(32'd0);
        #1 chk("readback_7", HRDATA, pdat[7]);
        chk("out_ssize", 32'(ssize), 32'd0);
        chk("out_dsize", 32'(dsize), 32'd1);
        chk("out_sinc", 32'(sinc), 32'd2);
        chk("out_dinc", 32'(dinc), 32'd4);
        chk("out_wfi", 32'(wfi), 32'd1);
        chk("out_irqsrc", 32'(irqsrc), 32'd3);
        chk("out_bsize", 32'(bsize), 32'h10);

        // Start handshake and lock
        wr32(32'h20, 32'h3);
        chk("start_pulse", 32'(start), 32'd1);
        idle(32'd0);
        #1 chk("start_one_cycle", 32'(start), 32'd0);
        busy = 1'b1;
        wr32(32'h00, 32'h1234);
        chk("saddr_locked", saddr, 32'h2000_0000);
        wr32(32'h20, 32'h1);
        chk("start_dropped", 32'(start), 32'd0);
        rd32(32'h24, 32'h1, "status_busy");
        busy = 1'b0;

        // Completion and interrupt
        wr32(32'h20, 32'h2);
        idle(32'd0);
        done = 1'b1;
        idle(32'd0);
        done = 1'b0;
        #1 chk("irq_set", 32'(irq), 32'd1);
        rd32(32'h24, 32'h2, "status_done");
        wr32(32'h24, 32'h2);
        chk("irq_w1c", 32'(irq), 32'd0);
        done = 1'b1;
        idle(32'd0);
        done = 1'b0;
        cyc(1'b1, 2'b10, 1'b1, 32'h24, 3'd2, 32'd0);
        idle(32'h2);
        done = 1'b1;
        idle(32'd0);
        done = 1'b0;
        #1 chk("set_wins", 32'(irq), 32'd1);
        wr32(32'h20, 32'h0);
        chk("irq_ie_off", 32'(irq), 32'd0);
        rd32(32'h24, 32'h2, "flag_kept");
        wr32(32'h20, 32'h1);
        chk("start_again", 32'(start), 32'd1);
        rd32(32'h24, 32'h0, "start_clears_flag");

        // Size and decode rules
        cyc(1'b1, 2'b10, 1'b1, 32'h0C, 3'd0, 32'd0);
        idle(32'hFF);
        idle(32'd0);
        chk("byte_write_ignored", 32'(bsize), 32'h10);
        rd32(32'h28, 32'd0, "unmapped_read");
        wr32(32'h28, 32'hFFFF_FFFF);
        cyc(1'b1, 2'b00, 1'b1, 32'h0C, 3'd2, 32'd0);
        idle(32'h55);
        idle(32'd0);
        chk("idle_no_write", 32'(bsize), 32'h10);
        cyc(1'b1, 2'b10, 1'b1, 32'h0C, 3'd2, 32'd0);
        HREADY = 1'b0;
        idle(32'h66);
        HREADY = 1'b1;
        idle(32'd0);
        chk("hready_low_no_write", 32'(bsize), 32'h10);
        wr32(32'h10, 32'h1FF);
        chk("bcount_field_width", 32'(bcount), 32'hFF);

        // Reset during a write data phase
        cyc(1'b1, 2'b10, 1'b1, 32'h00, 3'd2, 32'd0);
        idle(32'hDEAD_BEEF);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_saddr", saddr, 32'd0);
        chk("mid_rst_bsize", 32'(bsize), 32'd0);
        idle(32'd0);
        idle(32'd0);
        HRESETn = 1'b1;
        #1 chk("post_rst_saddr", saddr, 32'd0);
        for (int i = 0; i < 10; i++) rd32(32'(i * 4), 32'd0, $sformatf("post_rst_rd_%0d", i));
        idle(32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
